// File: rtl/seq_div32.sv
// seq_div32: multi-cycle restoring divider, one shift-subtract step per clock,
// signed (truncating) or unsigned, with start/done handshake and status flags.
module seq_div32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   dq_q, dq_d;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   remo_q, remo_d;
  logic               zero_q, zero_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  logic               a_neg, b_neg, ge;
  logic [WIDTH:0]     pr;
  logic [WIDTH-1:0]   qf, rf;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    a_neg = sgn_q & a_q[WIDTH-1];
    b_neg = sgn_q & b_q[WIDTH-1];
    pr    = {rem_q, dq_q[WIDTH-1]};
    ge    = (pr >= {1'b0, bmag_q});
    qf    = q_neg_q ? (WIDTH'(0) - dq_q) : dq_q;
    rf    = r_neg_q ? (WIDTH'(0) - rem_q) : rem_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = signed_op;
          busy_d  = 1'b1;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        q_neg_d = a_neg ^ b_neg;
        r_neg_d = a_neg;
        dq_d    = a_neg ? (WIDTH'(0) - a_q) : a_q;
        bmag_d  = b_neg ? (WIDTH'(0) - b_q) : b_q;
        rem_d   = '0;
        cnt_d   = CNT_W'(WIDTH);
        if (b_q == '0) begin
          quot_d  = '1;
          remo_d  = a_q;
          zero_d  = 1'b0;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (sgn_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1)) begin
          quot_d  = {1'b1, {(WIDTH-1){1'b0}}};
          remo_d  = '0;
          zero_d  = 1'b0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        rem_d = ge ? (pr[WIDTH-1:0] - bmag_q) : pr[WIDTH-1:0];
        dq_d  = {dq_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        quot_d  = qf;
        remo_d  = rf;
        zero_d  = (qf == '0);
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dq_q    <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
